// File: rtl/pipe_ctrl_pkg.sv
// Shared codes, FSM encoding and per-stage decode for the pipeline hazard controller.
package pipe_ctrl_pkg;

  localparam logic [1:0] CTRL_STATE_Default = 2'b00;
  localparam logic [1:0] CTRL_STATE_Stall   = 2'b01;
  localparam logic [1:0] CTRL_STATE_Branch  = 2'b10;

  localparam int FSM_Wire_Bus = 1;

  typedef enum logic [FSM_Wire_Bus-1:0] {
    FSM_STATE_Run  = 1'b0,
    FSM_STATE_Hold = 1'b1
  } fsm_state_e;

  // All-ones is never a legal fetch address; ADDR_W is at most 64.
  localparam logic [63:0] Invalid_pc = 64'hFFFF_FFFF_FFFF_FFFF;

  // Winning event of the cycle; each maps to one code pattern across the stages.
  typedef enum logic [2:0] {
    ACT_RESET      = 3'd0,
    ACT_MEM_STALL  = 3'd1,
    ACT_HOLD_STALL = 3'd2,
    ACT_REDIRECT   = 3'd3,
    ACT_LOAD_USE   = 3'd4,
    ACT_IMISS      = 3'd5,
    ACT_HOLD       = 3'd6,
    ACT_NONE       = 3'd7
  } ctrl_act_e;

  function automatic logic [1:0] stage_code(input ctrl_act_e act, input int k,
                                            input int nstage, input int ex_idx);
    logic [1:0] c;
    c = CTRL_STATE_Default;
    case (act)
      ACT_RESET:      c = (k == 0) ? CTRL_STATE_Stall : CTRL_STATE_Branch;
      ACT_MEM_STALL:  c = (k == nstage - 1) ? CTRL_STATE_Branch : CTRL_STATE_Stall;
      ACT_HOLD_STALL: c = (k == 0 || k == nstage - 1) ? CTRL_STATE_Branch : CTRL_STATE_Stall;
      ACT_REDIRECT:   c = (k <= ex_idx) ? CTRL_STATE_Branch : CTRL_STATE_Default;
      ACT_LOAD_USE:   c = (k < ex_idx) ? CTRL_STATE_Stall :
                          (k == ex_idx) ? CTRL_STATE_Branch : CTRL_STATE_Default;
      ACT_IMISS:      c = (k == 0) ? CTRL_STATE_Stall :
                          (k == 1) ? CTRL_STATE_Branch : CTRL_STATE_Default;
      ACT_HOLD:       c = (k <= 1) ? CTRL_STATE_Branch : CTRL_STATE_Default;
      default:        c = CTRL_STATE_Default;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/pipe_ctrl_reg.sv
// Generic state register with asynchronous active-high reset to a fixed value.
module pipe_ctrl_reg #(
  parameter int             W       = 1,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Holds the next-state value presented by the controller.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RST_VAL;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: arbitrates mem-busy, redirect, load-use and I-miss
// into per-register control codes and holds the fetch redirect for HOLD_CYC cycles.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int NSTAGE   = 5,
  parameter int EX_IDX   = 2,
  parameter int ADDR_W   = 64,
  parameter int HOLD_CYC = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                icache_data_valid_i,
  input  logic                mem_busy_i,
  input  logic                id_load_use_i,
  input  logic                ex_redirect_i,
  input  logic [ADDR_W-1:0]   ex_pc_new_i,
  output logic [2*NSTAGE-1:0] ctrl_signal_o,
  output logic [ADDR_W-1:0]   ctrl_to_pc_new_o,
  output logic                ctrl_busy_o
);

  localparam logic [ADDR_W-1:0] INV_PC    = Invalid_pc[ADDR_W-1:0];
  localparam logic [3:0]        HOLD_LOAD = 4'(HOLD_CYC);

  logic [FSM_Wire_Bus-1:0] state_bits_r;
  fsm_state_e              state_r;
  fsm_state_e              state_next_s;
  logic [3:0]              cnt_r;
  logic [3:0]              cnt_next_s;
  logic [ADDR_W-1:0]       tgt_r;
  logic [ADDR_W-1:0]       tgt_next_s;
  logic [ADDR_W-1:0]       pc_new_s;
  ctrl_act_e               act_s;

  pipe_ctrl_reg #(.W(FSM_Wire_Bus), .RST_VAL(FSM_Wire_Bus'(FSM_STATE_Run))) u_state_reg (
    .clk (clk), .rst (rst), .d (state_next_s), .q (state_bits_r)
  );

  pipe_ctrl_reg #(.W(4), .RST_VAL(4'd0)) u_cnt_reg (
    .clk (clk), .rst (rst), .d (cnt_next_s), .q (cnt_r)
  );

  pipe_ctrl_reg #(.W(ADDR_W), .RST_VAL(INV_PC)) u_tgt_reg (
    .clk (clk), .rst (rst), .d (tgt_next_s), .q (tgt_r)
  );

  assign state_r = fsm_state_e'(state_bits_r);

  // Event arbitration and next-state selection; rst gates outputs immediately.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    tgt_next_s   = tgt_r;
    pc_new_s     = INV_PC;
    act_s        = ACT_NONE;
    if (rst) begin
      act_s = ACT_RESET;
    end else if (state_r == FSM_STATE_Hold) begin
      if (mem_busy_i) begin
        act_s    = ACT_HOLD_STALL;
        pc_new_s = tgt_r;
      end else if (ex_redirect_i) begin
        act_s      = ACT_REDIRECT;
        pc_new_s   = ex_pc_new_i;
        tgt_next_s = ex_pc_new_i;
        cnt_next_s = HOLD_LOAD;
      end else begin
        act_s      = ACT_HOLD;
        pc_new_s   = tgt_r;
        cnt_next_s = cnt_r - 4'd1;
        // A zero count here is unreachable, but must still release the hold.
        if (cnt_r <= 4'd1) begin
          state_next_s = FSM_STATE_Run;
        end else begin
          state_next_s = FSM_STATE_Hold;
        end
      end
    end else begin
      if (mem_busy_i) begin
        act_s = ACT_MEM_STALL;
      end else if (ex_redirect_i) begin
        act_s      = ACT_REDIRECT;
        pc_new_s   = ex_pc_new_i;
        tgt_next_s = ex_pc_new_i;
        if (HOLD_LOAD != 4'd0) begin
          state_next_s = FSM_STATE_Hold;
          cnt_next_s   = HOLD_LOAD;
        end else begin
          state_next_s = FSM_STATE_Run;
          cnt_next_s   = 4'd0;
        end
      end else if (id_load_use_i) begin
        act_s = ACT_LOAD_USE;
      end else if (!icache_data_valid_i) begin
        act_s = ACT_IMISS;
      end else begin
        act_s = ACT_NONE;
      end
    end
  end

  for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
    assign ctrl_signal_o[2*k +: 2] = stage_code(act_s, k, NSTAGE, EX_IDX);
  end

  assign ctrl_to_pc_new_o = pc_new_s;
  assign ctrl_busy_o      = (state_r == FSM_STATE_Hold) && !rst;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed plus randomized bench for pipe_ctrl, checked against a behavioural model
// for two instances (HOLD_CYC=1 and HOLD_CYC=3).
module tb_pipe_ctrl;

  localparam int N  = 5;
  localparam int EX = 2;
  localparam int AW = 64;
  localparam logic [63:0] INV = 64'hFFFF_FFFF_FFFF_FFFF;

  logic          clk;
  logic          rst;
  logic          ic_valid;
  logic          mem_busy;
  logic          load_use;
  logic          redir;
  logic [AW-1:0] pc_new;
  logic [2*N-1:0] ctrl_a, ctrl_b;
  logic [AW-1:0]  pco_a, pco_b;
  logic           busy_a, busy_b;

  int n_vec  = 0;
  int n_miss = 0;

  // model state: remaining HOLD cycles and latched target, per instance
  int          hl[2];
  logic [63:0] mtgt[2];
  int          hcyc[2];

  logic [2*N-1:0] obs_ctrl, obs3_ctrl;
  logic [63:0]    obs_pc;
  logic           obs_busy, obs3_busy;

  pipe_ctrl #(.NSTAGE(N), .EX_IDX(EX), .ADDR_W(AW), .HOLD_CYC(1)) dut (
    .clk(clk), .rst(rst), .icache_data_valid_i(ic_valid), .mem_busy_i(mem_busy),
    .id_load_use_i(load_use), .ex_redirect_i(redir), .ex_pc_new_i(pc_new),
    .ctrl_signal_o(ctrl_a), .ctrl_to_pc_new_o(pco_a), .ctrl_busy_o(busy_a)
  );

  pipe_ctrl #(.NSTAGE(N), .EX_IDX(EX), .ADDR_W(AW), .HOLD_CYC(3)) dut3 (
    .clk(clk), .rst(rst), .icache_data_valid_i(ic_valid), .mem_busy_i(mem_busy),
    .id_load_use_i(load_use), .ex_redirect_i(redir), .ex_pc_new_i(pc_new),
    .ctrl_signal_o(ctrl_b), .ctrl_to_pc_new_o(pco_b), .ctrl_busy_o(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected outputs from the priority rules, for the current inputs and model state.
  task automatic model_expect(input int i, output logic [2*N-1:0] c,
                              output logic [63:0] p, output logic b);
    int code[N];
    for (int k = 0; k < N; k++) code[k] = 0;
    p = INV;
    b = 1'b0;
    if (rst) begin
      code[0] = 1;
      for (int k = 1; k < N; k++) code[k] = 2;
    end else if (hl[i] > 0) begin
      b = 1'b1;
      if (mem_busy) begin
        for (int k = 0; k < N - 1; k++) code[k] = 1;
        code[N-1] = 2;
        code[0]   = 2;
        p = mtgt[i];
      end else if (redir) begin
        for (int k = 0; k <= EX; k++) code[k] = 2;
        p = pc_new;
      end else begin
        code[0] = 2;
        code[1] = 2;
        p = mtgt[i];
      end
    end else begin
      if (mem_busy) begin
        for (int k = 0; k < N - 1; k++) code[k] = 1;
        code[N-1] = 2;
      end else if (redir) begin
        for (int k = 0; k <= EX; k++) code[k] = 2;
        p = pc_new;
      end else if (load_use) begin
        for (int k = 0; k < EX; k++) code[k] = 1;
        code[EX] = 2;
      end else if (!ic_valid) begin
        code[0] = 1;
        code[1] = 2;
      end
    end
    c = '0;
    for (int k = 0; k < N; k++) c[2*k +: 2] = 2'(code[k]);
  endtask

  task automatic model_step(input int i);
    if (rst) begin
      hl[i] = 0;
      mtgt[i] = INV;
    end else if (mem_busy) begin
      hl[i] = hl[i];
    end else if (redir) begin
      mtgt[i] = pc_new;
      hl[i] = hcyc[i];
    end else if (hl[i] > 0) begin
      hl[i] = hl[i] - 1;
    end
  endtask

  task automatic check_now();
    logic [2*N-1:0] c;
    logic [63:0]    p;
    logic           b;
    obs_ctrl = ctrl_a; obs_pc = pco_a; obs_busy = busy_a;
    obs3_ctrl = ctrl_b; obs3_busy = busy_b;
    model_expect(0, c, p, b);
    chk("h1_ctrl", 64'(ctrl_a), 64'(c));
    chk("h1_pc",   pco_a, p);
    chk("h1_busy", 64'(busy_a), 64'(b));
    model_expect(1, c, p, b);
    chk("h3_ctrl", 64'(ctrl_b), 64'(c));
    chk("h3_pc",   pco_b, p);
    chk("h3_busy", 64'(busy_b), 64'(b));
  endtask

  task automatic cycle();
    @(negedge clk);
    check_now();
    @(posedge clk);
    #1;
    model_step(0);
    model_step(1);
  endtask

  task automatic idle(input int n);
    ic_valid = 1'b1; mem_busy = 1'b0; load_use = 1'b0; redir = 1'b0;
    for (int j = 0; j < n; j++) cycle();
  endtask

  initial begin
    int hold_cnt;
    hcyc[0] = 1; hcyc[1] = 3;
    hl[0] = 0; hl[1] = 0;
    mtgt[0] = INV; mtgt[1] = INV;
    rst = 1'b1; ic_valid = 1'b1; mem_busy = 1'b0; load_use = 1'b0; redir = 1'b0;
    pc_new = 64'h0;

    // reset pattern
    cycle();
    chk("rst_ctrl", 64'(obs_ctrl), 64'(10'b10_10_10_10_01));
    chk("rst_pc", obs_pc, INV);
    chk("rst_busy", 64'(obs_busy), 64'd0);
    rst = 1'b0;
    idle(1);

    // redirect with HOLD_CYC=1
    redir = 1'b1; pc_new = 64'h0000_0000_8000_0100;
    cycle();
    chk("redir_ctrl", 64'(obs_ctrl), 64'(10'b00_00_10_10_10));
    chk("redir_pc", obs_pc, 64'h0000_0000_8000_0100);
    redir = 1'b0; pc_new = 64'h0;
    cycle();
    chk("hold_ctrl", 64'(obs_ctrl), 64'(10'b00_00_00_10_10));
    chk("hold_busy", 64'(obs_busy), 64'd1);
    chk("hold_pc", obs_pc, 64'h0000_0000_8000_0100);
    cycle();
    chk("post_hold_ctrl", 64'(obs_ctrl), 64'(10'b0));
    chk("post_hold_pc", obs_pc, INV);
    idle(3);

    // load-use for one cycle
    load_use = 1'b1;
    cycle();
    chk("lu_ctrl", 64'(obs_ctrl), 64'(10'b00_00_10_01_01));
    load_use = 1'b0;
    cycle();
    chk("lu_after", 64'(obs_ctrl), 64'(10'b0));

    // mem busy masks redirect for three cycles
    mem_busy = 1'b1; redir = 1'b1; pc_new = 64'h0000_0000_8000_2000;
    for (int j = 0; j < 3; j++) begin
      cycle();
      chk("membusy_ctrl", 64'(obs_ctrl), 64'(10'b10_01_01_01_01));
    end
    mem_busy = 1'b0;
    cycle();
    chk("late_redir_ctrl", 64'(obs_ctrl), 64'(10'b00_00_10_10_10));
    chk("late_redir_pc", obs_pc, 64'h0000_0000_8000_2000);
    idle(5);

    // HOLD_CYC=3 instance with mem busy in the second hold cycle
    redir = 1'b1; pc_new = 64'h0000_0000_4000_0040;
    cycle();
    redir = 1'b0;
    cycle();
    hold_cnt = obs3_busy ? 1 : 0;
    mem_busy = 1'b1;
    cycle();
    hold_cnt += obs3_busy ? 1 : 0;
    mem_busy = 1'b0;
    for (int j = 0; j < 8; j++) begin
      cycle();
      hold_cnt += obs3_busy ? 1 : 0;
    end
    chk("h3_hold_len", 64'(hold_cnt), 64'd4);

    // icache miss priority
    ic_valid = 1'b0; load_use = 1'b1;
    cycle();
    chk("imiss_lu_ctrl", 64'(obs_ctrl), 64'(10'b00_00_10_01_01));
    load_use = 1'b0;
    cycle();
    chk("imiss_ctrl", 64'(obs_ctrl), 64'(10'b00_00_00_10_01));
    idle(1);

    // asynchronous reset in the middle of HOLD
    redir = 1'b1; pc_new = 64'h0000_0000_1234_5670;
    cycle();
    redir = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_now();
    chk("async_rst_ctrl", 64'(obs3_ctrl), 64'(10'b10_10_10_10_01));
    chk("async_rst_busy", 64'(obs3_busy), 64'd0);
    hl[0] = 0; hl[1] = 0; mtgt[0] = INV; mtgt[1] = INV;
    cycle();
    rst = 1'b0;
    cycle();
    chk("rel_busy", 64'(obs3_busy), 64'd0);
    chk("rel_ctrl", 64'(obs3_ctrl), 64'(10'b0));

    // randomized traffic
    for (int j = 0; j < 400; j++) begin
      rst      = ($urandom_range(0, 99) == 0);
      ic_valid = ($urandom_range(0, 4) != 0);
      mem_busy = ($urandom_range(0, 3) == 0);
      load_use = ($urandom_range(0, 5) == 0);
      redir    = ($urandom_range(0, 7) == 0);
      pc_new   = {$urandom, $urandom};
      cycle();
    end
    idle(6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Parametrised pipeline hazard controller for the in-order RISC-V core. It drives one 2-bit control code per pipeline register: PC, IF/ID, ID/EX, EX/MEM, MEM/WB, extendable to deeper pipelines. It arbitrates four events: data-cache busy, EX-stage redirect (taken branch/jal/jalr), load-use hazard and I-cache miss. After a redirect it holds the fetch redirect for a programmable number of cycles. Sits beside the datapath; all pipeline registers and the PC unit take their `CTRL_STATE_*` code from it.

## Interface
- NSTAGE, 5: number of controlled registers; index 0 = PC, index NSTAGE-1 = last (MEM/WB). Legal range 5..8.
- EX_IDX, 2: index of the register feeding EX (ID/EX). Legal range 2..NSTAGE-2.
- ADDR_W, 64: PC width.
- HOLD_CYC, 1: redirect hold cycles after the redirect cycle. Legal range 0..15.
- clk  in  1  clock.
- rst  in  1  reset. Asynchronous, active-high.
- icache_data_valid_i  in  1  fetch data valid this cycle; 0 = I-cache miss.
- mem_busy_i  in  1  MEM stage cannot complete this cycle.
- id_load_use_i  in  1  ID instruction depends on a load currently in EX.
- ex_redirect_i  in  1  EX resolved a taken branch, jal or jalr.
- ex_pc_new_i  in  ADDR_W  redirect target, valid with ex_redirect_i.
- ctrl_signal_o  out  2*NSTAGE  code for register k at bits [2k+1:2k].
- ctrl_to_pc_new_o  out  ADDR_W  redirect target; `Invalid_pc` when PC code is not REDIRECT.
- ctrl_busy_o  out  1  high while in HOLD.

## Operation
- Codes: NORMAL 2'b00 advances. STALL 2'b01 holds. FLUSH 2'b10 loads a bubble (for the PC it means REDIRECT: load ctrl_to_pc_new_o).
- FSM has two states, RUN and HOLD. Registered state: a 4-bit counter `cnt` and an ADDR_W target `tgt`.
- RUN outputs, evaluated in strict priority order; unlisted registers are NORMAL.
  1. mem_busy_i: registers 0..NSTAGE-2 STALL, NSTAGE-1 FLUSH.
  2. ex_redirect_i: PC REDIRECT with target ex_pc_new_i; registers 1..EX_IDX FLUSH. Latch tgt. If HOLD_CYC>0, go to HOLD with cnt=HOLD_CYC.
  3. id_load_use_i: registers 0..EX_IDX-1 STALL, EX_IDX FLUSH.
  4. !icache_data_valid_i: PC STALL, IF/ID FLUSH.
- A lower-priority event is ignored in a cycle where a higher one wins. The held stages keep re-presenting it, so it is serviced later.
- HOLD outputs: PC REDIRECT with tgt; IF/ID FLUSH; all other registers NORMAL. Each cycle cnt decrements. When cnt reaches 1, the next state is RUN.
- HOLD with mem_busy_i: mem-stall outputs apply, except the PC stays REDIRECT with tgt. cnt is frozen.
- HOLD with ex_redirect_i (defensive only; EX holds a bubble): tgt and cnt reload. The new target is output in the same cycle.
- icache miss and load-use are ignored in HOLD.

## Timing
- Outputs are combinational from state and inputs in the same cycle. State and tgt update on the rising clk edge.
- Redirect latency: the target appears on ctrl_to_pc_new_o in the same cycle as ex_redirect_i and stays for HOLD_CYC further cycles. A new fetch begins after 1+HOLD_CYC cycles.
- While rst is high: state RUN, cnt 0, tgt `Invalid_pc`, ctrl_busy_o 0. PC code STALL, all other codes FLUSH, ctrl_to_pc_new_o `Invalid_pc`.
- Reset asserted mid-HOLD aborts the hold immediately (asynchronous).
- Deassertion is synchronous to the first clk edge, which takes effect from RUN.

## Structure
- defines.v holds:
  - `CTRL_STATE_Default` (00), `CTRL_STATE_Stall` (01), `CTRL_STATE_Branch` (10).
  - `FSM_STATE_Run` and `FSM_STATE_Hold`, plus `FSM_Wire_Bus`.
  - `Invalid_pc`.
- State, cnt and tgt use the existing `Reg` sub-module, with reset values `FSM_STATE_Run`, 0 and `Invalid_pc`.
- Per-stage code generation is one generate loop over k, using the index rules above.

## Test plan
- Defaults (NSTAGE=5, EX_IDX=2, HOLD_CYC=1). Pulse ex_redirect_i with target 0x80000100 → cycle 0 ctrl_signal_o=10'b00_00_10_10_10 and pc_new 0x80000100. Cycle 1: PC REDIRECT, IF/ID FLUSH, ctrl_busy_o=1. Cycle 2: all NORMAL, pc_new `Invalid_pc`.
- id_load_use_i for 1 cycle → 10'b00_00_10_01_01, then all NORMAL.
- mem_busy_i together with ex_redirect_i for 3 cycles, then mem_busy_i drops → 3 cycles of 10'b10_01_01_01_01, then the redirect cycle.
- HOLD_CYC=3 with mem_busy_i in the second HOLD cycle → HOLD lasts 4 cycles. tgt is constant and the PC is REDIRECT throughout.
- icache_data_valid_i=0 together with id_load_use_i → load-use pattern wins. With icache miss alone → PC STALL, IF/ID FLUSH.
- rst asserted in mid-HOLD → outputs switch immediately to the reset pattern. After release the FSM is in RUN with ctrl_busy_o=0.
